// File: rtl/cmpx_accumulator.sv
// -----------------------------------------------------------------------------
// cmpx_accumulator
//
// Sums COUNT complex products delivered by an external complex multiplier.
// For every term the FSM asks the multiplier for a product with a one-cycle
// mult_start pulse. It waits for a rising edge on prod_valid and captures the
// product. It then adds the sign-extended real and imaginary parts to two
// independent ACC_W-bit accumulators.
//
// States: IDLE -> REQ -> WAIT -> ACC -> (REQ ... | DONE) ; DONE -> REQ on start.
//
// Parameters
//   COUNT  number of products per accumulation (1..15)
//   ACC_W  accumulator width in bits (8..16)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   begin a new accumulation (honoured in IDLE and DONE only)
//   prod_re     in   8-bit two's complement real part of the product
//   prod_im     in   8-bit two's complement imaginary part of the product
//   prod_valid  in   multiplier done level; only its rising edge is used
//   mult_start  out  one-cycle request for the next product
//   acc_re      out  real accumulator (ACC_W, two's complement)
//   acc_im      out  imaginary accumulator (ACC_W, two's complement)
//   term_cnt    out  number of products accumulated so far
//   busy        out  high in REQ, WAIT and ACC
//   done        out  high in DONE
//   ovf         out  sticky overflow flag
//
// Configuration macro
//   CMPX_ACC_SAT_EN  defined: each accumulator saturates on signed overflow
//                    and sets the sticky ovf flag.
//                    undefined (default): accumulators wrap modulo 2^ACC_W
//                    and ovf is tied to 0.
// -----------------------------------------------------------------------------
module cmpx_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       prod_re,
  input  logic [7:0]       prod_im,
  input  logic             prod_valid,
  output logic             mult_start,
  output logic [ACC_W-1:0] acc_re,
  output logic [ACC_W-1:0] acc_im,
  output logic [3:0]       term_cnt,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [3:0] COUNT_C = 4'(COUNT);

  // Sign-extend an 8-bit two's complement value to the accumulator width.
  function automatic logic [ACC_W-1:0] sext8(input logic [7:0] v);
    logic signed [7:0] sv;
    sv = v;
    return ACC_W'(sv);
  endfunction

`ifdef CMPX_ACC_SAT_EN
  // Signed add with clamping; MSB of the result is the overflow indication.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] res;
    logic             o;
    wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Disagreeing top two bits of the one-bit-wider sum flag signed overflow.
    case (wide[ACC_W:ACC_W-1])
      2'b01: begin
        res = {1'b0, {(ACC_W-1){1'b1}}};
        o   = 1'b1;
      end
      2'b10: begin
        res = {1'b1, {(ACC_W-1){1'b0}}};
        o   = 1'b1;
      end
      default: begin
        res = wide[ACC_W-1:0];
        o   = 1'b0;
      end
    endcase
    return {o, res};
  endfunction
`endif

  state_e           state_q;
  logic             mult_start_q;
  logic             busy_q;
  logic             done_q;
  logic [ACC_W-1:0] acc_re_q;
  logic [ACC_W-1:0] acc_im_q;
  logic [3:0]       term_cnt_q;
  logic [7:0]       cap_re_q;
  logic [7:0]       cap_im_q;
  logic             pv_prev_q;

  logic [ACC_W-1:0] acc_re_d;
  logic [ACC_W-1:0] acc_im_d;
  logic [3:0]       term_cnt_d;

`ifdef CMPX_ACC_SAT_EN
  logic             ovf_q;
  logic             ovf_re_d;
  logic             ovf_im_d;

  // Next accumulator values, each path clamped on its own.
  always_comb begin
    {ovf_re_d, acc_re_d} = sat_add(acc_re_q, sext8(cap_re_q));
    {ovf_im_d, acc_im_d} = sat_add(acc_im_q, sext8(cap_im_q));
    term_cnt_d           = term_cnt_q + 4'd1;
  end
`else
  // Next accumulator values, plain modulo-2^ACC_W wrap.
  always_comb begin
    acc_re_d   = acc_re_q + sext8(cap_re_q);
    acc_im_d   = acc_im_q + sext8(cap_im_q);
    term_cnt_d = term_cnt_q + 4'd1;
  end
`endif

  // Main FSM with registered outputs and the prod_valid edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mult_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      term_cnt_q   <= 4'd0;
      cap_re_q     <= 8'd0;
      cap_im_q     <= 8'd0;
      pv_prev_q    <= 1'b0;
`ifdef CMPX_ACC_SAT_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      // History tracks prod_valid in every state so a level left high by the
      // previous product never looks like a fresh edge in WAIT.
      pv_prev_q    <= prod_valid;
      mult_start_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_REQ;
            mult_start_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            acc_re_q     <= '0;
            acc_im_q     <= '0;
            term_cnt_q   <= 4'd0;
`ifdef CMPX_ACC_SAT_EN
            ovf_q        <= 1'b0;
`endif
          end else begin
            state_q <= state_q;
          end
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (prod_valid && !pv_prev_q) begin
            cap_re_q <= prod_re;
            cap_im_q <= prod_im;
            state_q  <= ST_ACC;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_ACC: begin
          acc_re_q   <= acc_re_d;
          acc_im_q   <= acc_im_d;
          term_cnt_q <= term_cnt_d;
`ifdef CMPX_ACC_SAT_EN
          ovf_q      <= ovf_q | ovf_re_d | ovf_im_d;
`endif
          if (term_cnt_d == COUNT_C) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q      <= ST_REQ;
            mult_start_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mult_start = mult_start_q;
  assign acc_re     = acc_re_q;
  assign acc_im     = acc_im_q;
  assign term_cnt   = term_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef CMPX_ACC_SAT_EN
  assign ovf        = ovf_q;
`else
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_cmpx_accumulator.sv
// -----------------------------------------------------------------------------
// tb_cmpx_accumulator
//
// Two instances share the product inputs. dut_a has COUNT=4 and ACC_W=12.
// dut_b has COUNT=2 and ACC_W=8. `sel` picks which one receives start and
// which one is observed. A small behavioural multiplier answers every
// mult_start after a random latency and holds prod_valid high for a chosen
// number of cycles. Expected sums come from integer arithmetic on the product
// list, with a clamp or modulo correction after each term.
// -----------------------------------------------------------------------------
module tb_cmpx_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sel;
  logic [7:0]  prod_re;
  logic [7:0]  prod_im;
  logic        prod_valid;
  logic        start_a, start_b;

  logic        ms_a, busy_a, done_a, ovf_a;
  logic [11:0] acc_re_a, acc_im_a;
  logic [3:0]  tc_a;
  logic        ms_b, busy_b, done_b, ovf_b;
  logic [7:0]  acc_re_b, acc_im_b;
  logic [3:0]  tc_b;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  cmpx_accumulator #(.COUNT(4), .ACC_W(12)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .prod_re(prod_re), .prod_im(prod_im), .prod_valid(prod_valid),
    .mult_start(ms_a), .acc_re(acc_re_a), .acc_im(acc_im_a),
    .term_cnt(tc_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  cmpx_accumulator #(.COUNT(2), .ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .prod_re(prod_re), .prod_im(prod_im), .prod_valid(prod_valid),
    .mult_start(ms_b), .acc_re(acc_re_b), .acc_im(acc_im_b),
    .term_cnt(tc_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pr [16];
  int pi [16];

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observation helpers for the currently selected instance.
  function automatic logic signed [31:0] o_re();
    logic signed [31:0] r;
    if (sel) r = $signed(acc_re_b); else r = $signed(acc_re_a);
    return r;
  endfunction
  function automatic logic signed [31:0] o_im();
    logic signed [31:0] r;
    if (sel) r = $signed(acc_im_b); else r = $signed(acc_im_a);
    return r;
  endfunction
  function automatic logic signed [31:0] o_tc();
    logic signed [31:0] r;
    if (sel) r = {28'd0, tc_b}; else r = {28'd0, tc_a};
    return r;
  endfunction
  function automatic logic o_ms();   return sel ? ms_b   : ms_a;   endfunction
  function automatic logic o_busy(); return sel ? busy_b : busy_a; endfunction
  function automatic logic o_done(); return sel ? done_b : done_a; endfunction
  function automatic logic o_ovf();  return sel ? ovf_b  : ovf_a;  endfunction

  // Reference: add one term to a w-bit signed accumulator.
  function automatic int add_term(input int a, input int p, input int w, output bit o);
    int hi, lo, r;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    r  = a + p;
    o  = 1'b0;
`ifdef CMPX_ACC_SAT_EN
    if (r > hi) begin r = hi; o = 1'b1; end
    else if (r < lo) begin r = lo; o = 1'b1; end
`else
    if (r > hi) r = r - (1 << w);
    else if (r < lo) r = r + (1 << w);
`endif
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ms"},   o_ms(),   0);
    check_eq({tag, "_busy"}, o_busy(), 0);
    check_eq({tag, "_done"}, o_done(), 0);
    check_eq({tag, "_ovf"},  o_ovf(),  0);
    check_eq({tag, "_tc"},   o_tc(),   0);
    check_eq({tag, "_re"},   o_re(),   0);
    check_eq({tag, "_im"},   o_im(),   0);
  endtask

  // One accumulation on instance s with cnt terms from pr/pi.
  task automatic run_job(input bit s, input int cnt, input int w,
                         input bit start_in_wait, input int abort_after,
                         input int hmin, input int hmax);
    int t, due, idx, hold, pulses, last_rise, req_t;
    bit pending, finished, o1, o2, exp_ov;
    int exp_re, exp_im;
    exp_re = 0; exp_im = 0; exp_ov = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      exp_re = add_term(exp_re, pr[k], w, o1);
      exp_im = add_term(exp_im, pi[k], w, o2);
      exp_ov = exp_ov | o1 | o2;
    end
    sel = s;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("start_ms",     o_ms(),   1);
    check_eq("start_busy",   o_busy(), 1);
    check_eq("start_clr_re", o_re(),   0);
    check_eq("start_clr_im", o_im(),   0);
    check_eq("start_clr_tc", o_tc(),   0);
    check_eq("start_clr_ovf", o_ovf(), 0);
    pulses = 1; t = 0; req_t = 0; idx = 0; hold = 0; last_rise = -100;
    due = $urandom_range(4, 1); pending = 1'b1; finished = 1'b0;
    while (!finished && t < 400) begin
      if (abort_after >= 0 && pulses == abort_after + 1 && t == req_t + 1) begin
        check_eq("abort_tc", o_tc(), abort_after);
        rst = 1'b1; prod_valid = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        return;
      end
      start = (start_in_wait && pulses == 1 && t == req_t + 1);
      if (hold > 0) begin
        prod_valid = 1'b1;
        hold--;
      end else if (pending && t >= due && prod_valid == 1'b0) begin
        prod_valid = 1'b1;
        prod_re    = pr[idx][7:0];
        prod_im    = pi[idx][7:0];
        hold       = $urandom_range(hmax, hmin) - 1;
        pending    = 1'b0;
        last_rise  = t;
        idx++;
      end else begin
        prod_valid = 1'b0;
      end
      @(negedge clk);
      t++;
      if (o_ms()) begin
        pulses++;
        check_eq("req_lat", t, last_rise + 2);
        req_t = t; due = t + $urandom_range(4, 1); pending = 1'b1;
      end
      if (o_done()) begin
        finished = 1'b1;
        check_eq("done_lat", t, last_rise + 2);
      end
    end
    start = 1'b0;
    check_eq("done_seen", finished, 1);
    check_eq("res_re",   o_re(),   exp_re);
    check_eq("res_im",   o_im(),   exp_im);
    check_eq("res_tc",   o_tc(),   cnt);
    check_eq("res_ovf",  o_ovf(),  exp_ov);
    check_eq("res_busy", o_busy(), 0);
    check_eq("pulses",   pulses,   cnt);
    // A prod_valid edge while in DONE must leave the result untouched.
    prod_valid = 1'b0;
    @(negedge clk);
    prod_valid = 1'b1; prod_re = 8'($urandom); prod_im = 8'($urandom);
    @(negedge clk);
    prod_valid = 1'b0;
    @(negedge clk);
    check_eq("hold_re",   o_re(),   exp_re);
    check_eq("hold_im",   o_im(),   exp_im);
    check_eq("hold_tc",   o_tc(),   cnt);
    check_eq("hold_done", o_done(), 1);
  endtask

  task automatic rand_products(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      pr[k] = int'($urandom_range(255, 0)) - 128;
      pi[k] = int'($urandom_range(255, 0)) - 128;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0;
    prod_valid = 1'b0; prod_re = 8'd0; prod_im = 8'd0;
    repeat (3) @(negedge clk);
    sel = 1'b0; check_all_zero("rst_a");
    sel = 1'b1; check_all_zero("rst_b");
    rst = 1'b0;

    // Four-term reference sum on the COUNT=4 instance.
    pr[0] = 1; pi[0] = 8; pr[1] = -2; pi[1] = 6;
    pr[2] = 1; pi[2] = 3; pr[3] = 0;  pi[3] = 0;
    run_job(1'b0, 4, 12, 1'b0, -1, 1, 3);

    // Long prod_valid levels must be accepted exactly once each.
    pr[0] = 3; pi[0] = -1; pr[1] = 3; pi[1] = -1;
    run_job(1'b1, 2, 8, 1'b0, -1, 5, 5);

    // Overflow on both paths in opposite directions.
    pr[0] = 100; pi[0] = -100; pr[1] = 100; pi[1] = -100;
    run_job(1'b1, 2, 8, 1'b0, -1, 1, 5);

    // Start pulsed in WAIT is ignored; this job also starts from DONE.
    rand_products(4);
    run_job(1'b0, 4, 12, 1'b1, -1, 1, 5);

    // Reset in WAIT after two terms, then a fresh accumulation.
    rand_products(4);
    run_job(1'b0, 4, 12, 1'b0, 2, 1, 4);
    rand_products(4);
    run_job(1'b0, 4, 12, 1'b0, -1, 1, 4);

    // Randomized jobs on both instances.
    for (int j = 0; j < 8; j++) begin
      if (j % 2 == 0) begin
        rand_products(4);
        run_job(1'b0, 4, 12, 1'b0, -1, 1, 5);
      end else begin
        rand_products(2);
        run_job(1'b1, 2, 8, 1'b0, -1, 1, 5);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmpx_accumulator.md
CMPX_ACCUMULATOR -- requirements
Module: cmpx_accumulator

Interface
REQ-001 The block SHALL have parameter COUNT, default 4, giving the number of complex products summed per accumulation (legal range 1..15).
REQ-002 The block SHALL have parameter ACC_W, default 12, giving the width of each accumulator (legal range 8..16).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a new accumulation; sampled in IDLE and DONE only.
REQ-007 prod_re  input  8  real part of the product from the complex multiplier, two's complement.
REQ-008 prod_im  input  8  imaginary part of the product, two's complement.
REQ-009 prod_valid  input  1  multiplier done level; may stay high for several cycles.
REQ-010 mult_start  output  1  one-cycle pulse telling the multiplier to compute the next product.
REQ-011 acc_re  output  ACC_W  real accumulator, two's complement.
REQ-012 acc_im  output  ACC_W  imaginary accumulator, two's complement.
REQ-013 term_cnt  output  4  number of products accumulated so far.
REQ-014 busy  output  1  high in REQ, WAIT and ACC.
REQ-015 done  output  1  high in DONE.
REQ-016 ovf  output  1  sticky overflow flag.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, WAIT, ACC and DONE, all registered on clk.
REQ-018 The FSM SHALL move from IDLE to REQ when start=1, and clear acc_re, acc_im, term_cnt and ovf on that same edge.
REQ-019 REQ SHALL assert mult_start=1 for exactly one cycle and then go unconditionally to WAIT.
REQ-020 mult_start SHALL be 0 in every state other than REQ.
REQ-021 WAIT SHALL accept a product only on a rising edge of prod_valid (prod_valid=1 and the registered previous value of prod_valid=0), and on acceptance capture prod_re and prod_im and go to ACC.
REQ-022 The previous-value register of prod_valid SHALL update every cycle in every state, so a stale high level left over from the prior product is never accepted.
REQ-023 ACC SHALL sign-extend each captured 8-bit value to ACC_W bits, add it to its accumulator and increment term_cnt.
REQ-024 From ACC the FSM SHALL go to DONE if the new term_cnt equals COUNT, and to REQ otherwise.
REQ-025 DONE SHALL hold done=1 and keep acc_re, acc_im, term_cnt and ovf stable.
REQ-026 From DONE, start=1 SHALL begin a new accumulation with the same clearing as REQ-018.
REQ-027 A start asserted in REQ, WAIT or ACC SHALL be ignored.
REQ-028 A prod_valid edge outside WAIT SHALL be ignored.
REQ-029 Latency: REQ to WAIT is 1 cycle, the accepting edge to ACC is 1 cycle, and ACC to DONE is 1 cycle after the final term.
REQ-030 A single term SHALL take 3 cycles plus the multiplier latency.
REQ-031 The real and imaginary paths SHALL be independent; overflow on one path SHALL NOT affect the other.

Reset
REQ-032 On rst=1 at a clock edge, the FSM SHALL enter IDLE and all outputs SHALL read 0 (mult_start, busy, done, ovf, term_cnt, acc_re, acc_im), and the prod_valid history register SHALL be cleared.
REQ-033 Reset SHALL take priority over start and prod_valid in every state, including mid-accumulation.
REQ-034 After a mid-accumulation reset, no partial result SHALL remain.

Configuration
REQ-035 The macro CMPX_ACC_SAT_EN SHALL select saturating accumulation.
REQ-036 With CMPX_ACC_SAT_EN defined, each accumulator SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on signed overflow and set ovf=1 (sticky until the next start or rst).
REQ-037 Without CMPX_ACC_SAT_EN, each accumulator SHALL wrap modulo 2^ACC_W and ovf SHALL be tied to 0.

Verification
REQ-038 COUNT=4, products (1,8),(-2,6),(1,3),(0,0) -> done=1 with acc_re=0, acc_im=17, term_cnt=4, and exactly 4 mult_start pulses.
REQ-039 prod_valid held high for 5 cycles per product -> each product is accumulated exactly once; COUNT=2 with (3,-1),(3,-1) gives (6,-2).
REQ-040 ACC_W=8, COUNT=2, products (100,-100) twice -> with SAT_EN: acc=(127,-128), ovf=1; without SAT_EN: acc=(-56,56), ovf=0.
REQ-041 rst asserted in WAIT after 2 of 4 terms -> the next cycle shows all outputs 0 in IDLE; a new start then gives a correct fresh sum.
REQ-042 start pulsed in WAIT -> ignored; start pulsed in DONE -> accumulators clear and mult_start pulses 1 cycle later.
